dnn_epoch_scheduler: RTL and testbench

- Sequences the DNN over full training runs, one step per block cycle (cycle_clk).
- Issues training-case addresses to the input and ideal-output memories, and gates weight updates (train vs. test phase).
- Steps the learning-rate shift etapos on a fixed epoch schedule.
- Counts correctly classified test cases per epoch and reports the count.

---
 rtl/dnn_epoch_scheduler_if.sv | 23 ++
 rtl/dnn_epoch_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_dnn_epoch_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_epoch_scheduler_if.sv
// Case-issue bus between the epoch scheduler and the DNN datapath:
// addresses and phase controls go out, per-case classification results come back.
interface dnn_epoch_scheduler_if #(
  parameter int AW    = 14,
  parameter int ETA_W = 4
);
  logic [AW-1:0]    tc_addr;
  logic             tc_valid;
  logic             train_en;
  logic [ETA_W-1:0] etapos;
  logic             result_valid;
  logic             result_correct;

  modport master (
    output tc_addr, tc_valid, train_en, etapos,
    input  result_valid, result_correct
  );

  modport slave (
    input  tc_addr, tc_valid, train_en, etapos,
    output result_valid, result_correct
  );
endinterface

// File: rtl/dnn_epoch_scheduler.sv
// Epoch sequencer for DNN training runs: issues train then test case addresses,
// steps the learning-rate shift on a fixed schedule and reports test accuracy.
module dnn_epoch_scheduler #(
  parameter int NUM_TRAIN       = 12544,
  parameter int NUM_TEST        = 2000,
  parameter int NUM_EPOCHS      = 8,
  parameter int ETA_W           = 4,
  parameter int ETA_INIT        = 3,
  parameter int ETA_STEP_EPOCHS = 2,
  parameter int ETA_MAX         = 7,
  parameter int PIPE_LAT        = 2
) (
  input  logic                              cycle_clk,
  input  logic                              reset,
  input  logic                              start,
  dnn_epoch_scheduler_if.master             bus,
  output logic [$clog2(NUM_EPOCHS+1)-1:0]   epoch,
  output logic [$clog2(NUM_TEST+1)-1:0]     test_correct,
  output logic                              acc_valid,
  output logic                              busy,
  output logic                              done
);
  localparam int AW = $clog2(NUM_TRAIN + NUM_TEST);
  localparam int EW = $clog2(NUM_EPOCHS + 1);
  localparam int CW = $clog2(NUM_TEST + 1);
  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [AW-1:0]    LAST_TRAIN = AW'(NUM_TRAIN - 1);
  localparam logic [AW-1:0]    FIRST_TEST = AW'(NUM_TRAIN);
  localparam logic [AW-1:0]    LAST_TEST  = AW'(NUM_TRAIN + NUM_TEST - 1);
  localparam logic [CW-1:0]    COUNT_MAX  = CW'(NUM_TEST);
  localparam logic [EW-1:0]    EPOCH_LAST = EW'(NUM_EPOCHS);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [ETA_W-1:0] ETA_INIT_V = ETA_W'(ETA_INIT);
  localparam logic [ETA_W-1:0] ETA_MAX_V  = ETA_W'(ETA_MAX);

  typedef enum logic [2:0] {S_IDLE, S_TRAIN, S_TEST, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       tc_addr_q, tc_addr_d;
  logic                tc_valid_q, tc_valid_d;
  logic                train_en_q, train_en_d;
  logic [ETA_W-1:0]    etapos_q, etapos_d;
  logic [EW-1:0]       epoch_q, epoch_d;
  logic [CW-1:0]       test_correct_q, test_correct_d;
  logic                acc_valid_q, acc_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;

  logic                count_hit;
  logic [EW-1:0]       epoch_inc;
  logic [31:0]         epoch_ext;

  // Tag line marks which in-flight results belong to test cases.
  assign tag_d[0] = tc_valid_q & ~train_en_q;
  for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_tag
    assign tag_d[gi] = tag_q[gi-1];
  end

  always_comb begin
    state_d        = state_q;
    tc_addr_d      = tc_addr_q;
    tc_valid_d     = tc_valid_q;
    train_en_d     = train_en_q;
    etapos_d       = etapos_q;
    epoch_d        = epoch_q;
    test_correct_d = test_correct_q;
    acc_valid_d    = 1'b0;
    busy_d         = busy_q;
    done_d         = done_q;
    drain_d        = drain_q;
    count_hit      = bus.result_valid & bus.result_correct & tag_q[PIPE_LAT-1];
    count_d        = (count_hit && count_q != COUNT_MAX) ? count_q + 1'b1 : count_q;
    epoch_inc      = epoch_q + 1'b1;
    epoch_ext      = 32'(epoch_inc);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_TRAIN;
          tc_addr_d  = '0;
          tc_valid_d = 1'b1;
          train_en_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          epoch_d    = '0;
          etapos_d   = ETA_INIT_V;
        end
      end
      S_TRAIN: begin
        if (tc_addr_q == LAST_TRAIN) begin
          state_d    = S_TEST;
          tc_addr_d  = FIRST_TEST;
          train_en_d = 1'b0;
          count_d    = '0;
        end else begin
          tc_addr_d = tc_addr_q + 1'b1;
        end
      end
      S_TEST: begin
        if (tc_addr_q == LAST_TEST) begin
          state_d    = S_DRAIN;
          tc_valid_d = 1'b0;
          drain_d    = '0;
        end else begin
          tc_addr_d = tc_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The last test result lands on the final drain edge, so report count_d.
        if (drain_q == DRAIN_LAST) begin
          test_correct_d = count_d;
          acc_valid_d    = 1'b1;
          epoch_d        = epoch_inc;
          if (epoch_inc == EPOCH_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if ((epoch_ext % 32'(ETA_STEP_EPOCHS)) == 32'd0 && etapos_q < ETA_MAX_V) begin
              etapos_d = etapos_q + 1'b1;
            end
            state_d    = S_TRAIN;
            tc_addr_d  = '0;
            tc_valid_d = 1'b1;
            train_en_d = 1'b1;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cycle_clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      tc_addr_q      <= '0;
      tc_valid_q     <= 1'b0;
      train_en_q     <= 1'b0;
      etapos_q       <= ETA_INIT_V;
      epoch_q        <= '0;
      test_correct_q <= '0;
      acc_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      count_q        <= '0;
      drain_q        <= '0;
      tag_q          <= '0;
    end else begin
      state_q        <= state_d;
      tc_addr_q      <= tc_addr_d;
      tc_valid_q     <= tc_valid_d;
      train_en_q     <= train_en_d;
      etapos_q       <= etapos_d;
      epoch_q        <= epoch_d;
      test_correct_q <= test_correct_d;
      acc_valid_q    <= acc_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      count_q        <= count_d;
      drain_q        <= drain_d;
      tag_q          <= tag_d;
    end
  end

  assign bus.tc_addr   = tc_addr_q;
  assign bus.tc_valid  = tc_valid_q;
  assign bus.train_en  = train_en_q;
  assign bus.etapos    = etapos_q;
  assign epoch         = epoch_q;
  assign test_correct  = test_correct_q;
  assign acc_valid     = acc_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_dnn_epoch_scheduler.sv
// Bench for dnn_epoch_scheduler: table vectors for one epoch, hand sequences for
// run end / restart / reset, then random traffic against a cycle-index reference model.
module tb_dnn_epoch_scheduler;
  localparam int NT = 4, NS = 3, NE = 3, ETA_W = 4, EI = 3, ES = 1, EM = 4, PL = 2;
  localparam int L  = NT + NS + PL;
  localparam int AW = $clog2(NT + NS);
  localparam int EW = $clog2(NE + 1);
  localparam int CW = $clog2(NS + 1);

  logic          cycle_clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] epoch;
  logic [CW-1:0] test_correct;
  logic          acc_valid, busy, done;

  dnn_epoch_scheduler_if #(.AW(AW), .ETA_W(ETA_W)) bus ();

  dnn_epoch_scheduler #(
    .NUM_TRAIN(NT), .NUM_TEST(NS), .NUM_EPOCHS(NE), .ETA_W(ETA_W), .ETA_INIT(EI),
    .ETA_STEP_EPOCHS(ES), .ETA_MAX(EM), .PIPE_LAT(PL)
  ) dut (
    .cycle_clk(cycle_clk), .reset(reset), .start(start), .bus(bus),
    .epoch(epoch), .test_correct(test_correct), .acc_valid(acc_valid),
    .busy(busy), .done(done)
  );

  always #5 cycle_clk = ~cycle_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: run position is a plain cycle index since the start edge.
  bit started;
  int mk;
  int tc_before;
  bit hit [0:63];

  function automatic int cnt(int e);
    int s = 0;
    for (int j = 0; j < NS; j++) s += int'(hit[e*L + NT + 1 + PL + j]);
    return (s > NS) ? NS : s;
  endfunction

  function automatic int eta_after(int e);
    int v = EI;
    for (int i = 1; i <= e; i++) if (i < NE && i % ES == 0 && v < EM) v++;
    return v;
  endfunction

  function automatic bit in_done();
    return started && ((mk - 1) / L >= NE);
  endfunction

  task automatic model_edge(bit st, bit rn, bit rv, bit rc);
    if (!rn) begin
      started = 0; mk = 0; tc_before = 0;
    end else if (!started || in_done()) begin
      if (st) begin
        if (started) tc_before = cnt(NE - 1);
        started = 1; mk = 1;
        foreach (hit[i]) hit[i] = 0;
      end else if (started && mk < NE*L + 2) begin
        mk++;
      end
    end else begin
      hit[mk] = rv & rc;
      mk++;
    end
  endtask

  task automatic check_model();
    int e_addr = 0, e_v = 0, e_t = 0, e_eta = EI, e_ep = 0, e_tc = 0, e_acc = 0, e_busy = 0, e_done = 0;
    bit addr_care = 1;
    int ep, pos;
    if (started) begin
      ep  = (mk - 1) / L;
      pos = (mk - 1) % L;
      if (ep >= NE) begin
        addr_care = 0; e_done = 1; e_ep = NE; e_eta = eta_after(NE);
        e_acc = (mk == NE*L + 1); e_tc = cnt(NE - 1);
      end else begin
        e_busy = 1; e_ep = ep; e_eta = eta_after(ep);
        e_acc = (pos == 0 && ep > 0);
        e_tc  = (ep > 0) ? cnt(ep - 1) : tc_before;
        if (pos < NT + NS) begin
          e_addr = pos; e_v = 1; e_t = (pos < NT);
        end else begin
          addr_care = 0;
        end
      end
    end else begin
      e_tc = tc_before;
    end
    if (addr_care) chk("mdl_tc_addr", int'(bus.tc_addr), e_addr);
    chk("mdl_tc_valid", int'(bus.tc_valid), e_v);
    chk("mdl_train_en", int'(bus.train_en), e_t);
    chk("mdl_etapos", int'(bus.etapos), e_eta);
    chk("mdl_epoch", int'(epoch), e_ep);
    chk("mdl_test_correct", int'(test_correct), e_tc);
    chk("mdl_acc_valid", int'(acc_valid), e_acc);
    chk("mdl_busy", int'(busy), e_busy);
    chk("mdl_done", int'(done), e_done);
  endtask

  task automatic step(bit st, bit rn, bit rv, bit rc);
    start = st; reset = rn; bus.result_valid = rv; bus.result_correct = rc;
    @(posedge cycle_clk);
    model_edge(st, rn, rv, rc);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rv, rc;
    int addr;
    bit v, t;
    int eta, ep, tc;
    bit acc, busy, done;
  } vec_t;
  vec_t tbl [10];

  task automatic run_table(string tag);
    step(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].addr >= 0) chk($sformatf("%s_c%0d_addr", tag, i+1), int'(bus.tc_addr), tbl[i].addr);
      chk($sformatf("%s_c%0d_valid", tag, i+1), int'(bus.tc_valid), int'(tbl[i].v));
      chk($sformatf("%s_c%0d_train", tag, i+1), int'(bus.train_en), int'(tbl[i].t));
      chk($sformatf("%s_c%0d_eta", tag, i+1), int'(bus.etapos), tbl[i].eta);
      chk($sformatf("%s_c%0d_epoch", tag, i+1), int'(epoch), tbl[i].ep);
      chk($sformatf("%s_c%0d_tcorr", tag, i+1), int'(test_correct), tbl[i].tc);
      chk($sformatf("%s_c%0d_acc", tag, i+1), int'(acc_valid), int'(tbl[i].acc));
      chk($sformatf("%s_c%0d_busy", tag, i+1), int'(busy), int'(tbl[i].busy));
      chk($sformatf("%s_c%0d_done", tag, i+1), int'(done), int'(tbl[i].done));
      step(0, 1, tbl[i].rv, tbl[i].rc);
    end
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_addr"}, int'(bus.tc_addr), 0);
    chk({tag, "_valid"}, int'(bus.tc_valid), 0);
    chk({tag, "_train"}, int'(bus.train_en), 0);
    chk({tag, "_eta"}, int'(bus.etapos), EI);
    chk({tag, "_epoch"}, int'(epoch), 0);
    chk({tag, "_tcorr"}, int'(test_correct), 0);
    chk({tag, "_acc"}, int'(acc_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    // {rv, rc, addr(-1 = don't care), valid, train_en, etapos, epoch, test_correct, acc, busy, done}
    tbl[0] = '{1, 0,  0, 1, 1, 3, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 0,  1, 1, 1, 3, 0, 0, 0, 1, 0};
    tbl[2] = '{1, 0,  2, 1, 1, 3, 0, 0, 0, 1, 0};
    tbl[3] = '{1, 0,  3, 1, 1, 3, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 0,  4, 1, 0, 3, 0, 0, 0, 1, 0};
    tbl[5] = '{1, 1,  5, 1, 0, 3, 0, 0, 0, 1, 0};
    tbl[6] = '{1, 1,  6, 1, 0, 3, 0, 0, 0, 1, 0};
    tbl[7] = '{1, 0, -1, 0, 0, 3, 0, 0, 0, 1, 0};
    tbl[8] = '{1, 1, -1, 0, 0, 3, 0, 0, 0, 1, 0};
    tbl[9] = '{1, 0,  0, 1, 1, 4, 1, 2, 1, 1, 0};
    started = 0; mk = 0; tc_before = 0;
    foreach (hit[i]) hit[i] = 0;
    bus.result_valid = 1'b0; bus.result_correct = 1'b0;

    repeat (3) step(0, 0, 0, 0);
    chk_reset_state("rst0");

    run_table("t1");
    // Rest of the run with no results; start pulse mid-TRAIN must be ignored.
    for (int c = 11; c <= 27; c++) begin
      if (c == 19) begin
        chk("ep2_acc", int'(acc_valid), 1);
        chk("ep2_tcorr", int'(test_correct), 0);
        chk("ep2_epoch", int'(epoch), 2);
        chk("ep2_eta", int'(bus.etapos), 4);
      end
      step(c == 12, 1, 0, 0);
    end
    chk("c28_done", int'(done), 1);
    chk("c28_busy", int'(busy), 0);
    chk("c28_epoch", int'(epoch), 3);
    chk("c28_eta", int'(bus.etapos), 4);
    chk("c28_acc", int'(acc_valid), 1);
    chk("c28_valid", int'(bus.tc_valid), 0);

    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    chk("done_hold", int'(done), 1);
    step(1, 1, 0, 0);
    chk("restart_epoch", int'(epoch), 0);
    chk("restart_eta", int'(bus.etapos), EI);
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_addr", int'(bus.tc_addr), 0);

    for (int c = 1; c <= 5; c++) step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    chk_reset_state("rst_mid");
    step(0, 1, 1, 1);
    run_table("t2");

    for (int c = 11; c <= 18; c++) step(0, 1, 0, 0);
    chk("noresult_acc", int'(acc_valid), 1);
    chk("noresult_tcorr", int'(test_correct), 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 59) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
